// File: rtl/mips_pkg.sv
// Shared types and default widths for the MIPS pipeline blocks.
package mips_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam int DATA_WIDTH     = 32;
    localparam int OP_WIDTH       = 5;
    localparam int TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register. Loads every cycle; a bubble loads all zeros.
module mem_wb_pipe_reg
    import mips_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int op_width   = OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bubble_i,
    input  logic                  reg_write_i,
    input  logic                  mem2reg_i,
    input  logic [data_width-1:0] read_data_i,
    input  logic [data_width-1:0] alu_result_i,
    input  logic [op_width-1:0]   write_reg_i,
    output logic                  reg_write_o,
    output logic                  mem2reg_o,
    output logic [data_width-1:0] read_data_o,
    output logic [data_width-1:0] alu_result_o,
    output logic [op_width-1:0]   write_reg_o
);

    logic                  reg_write_q, mem2reg_q;
    logic [data_width-1:0] read_data_q, alu_result_q;
    logic [op_width-1:0]   write_reg_q;

    // Capture the instruction, or zeros when a bubble is requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble_i) begin
            reg_write_q  <= 1'b0;
            mem2reg_q    <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_i;
            mem2reg_q    <= mem2reg_i;
            read_data_q  <= read_data_i;
            alu_result_q <= alu_result_i;
            write_reg_q  <= write_reg_i;
        end
    end

    assign reg_write_o  = reg_write_q;
    assign mem2reg_o    = mem2reg_q;
    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;
    assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory stage: handshaked data-memory access with stall, misalignment
// and timeout detection; faults become write-back bubbles plus an error pulse.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int data_width     = DATA_WIDTH,
    parameter int op_width       = OP_WIDTH,
    parameter int timeout_cycles = TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_m,
    input  logic                  mem2reg_m,
    input  logic                  mem_write_m,
    input  logic [data_width-1:0] alu_result_m,
    input  logic [data_width-1:0] write_data_m,
    input  logic [op_width-1:0]   write_reg_m,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [data_width-1:0] dmem_addr,
    output logic [data_width-1:0] dmem_wdata,
    input  logic [data_width-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall_m,
    output logic                  reg_write_w,
    output logic                  mem2reg_w,
    output logic [data_width-1:0] read_data_w,
    output logic [data_width-1:0] alu_result_w,
    output logic [op_width-1:0]   write_reg_w,
    output logic                  mem_err
);

    localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(timeout_cycles - 1);

    mem_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  stall_d, bubble_d;
    logic [data_width-1:0] rdata_d;

    logic mem_op, aligned;
    assign mem_op  = mem2reg_m | mem_write_m;
    assign aligned = (alu_result_m[1:0] == 2'b00);

    // State, wait counter and registered error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state, memory port drive, stall and MEM/WB load selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        stall_d    = 1'b0;
        bubble_d   = 1'b1;
        rdata_d    = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    bubble_d = 1'b0;
                end else if (aligned) begin
                    stall_d = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = mem_write_m;
                dmem_addr  = alu_result_m;
                dmem_wdata = write_data_m;
                if (dmem_ack) begin
                    // Ack in the final wait cycle still completes normally.
                    bubble_d = 1'b0;
                    rdata_d  = mem2reg_m ? dmem_rdata : '0;
                    state_d  = IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    // Abort: release upstream so the faulting instruction drops.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must release the pipeline immediately even if a memory op is presented.
    assign stall_m = stall_d & ~reset;
    assign mem_err = err_q;

    mem_wb_pipe_reg #(
        .data_width (data_width),
        .op_width   (op_width)
    ) u_mem_wb (
        .clk          (clk),
        .reset        (reset),
        .bubble_i     (bubble_d),
        .reg_write_i  (reg_write_m),
        .mem2reg_i    (mem2reg_m),
        .read_data_i  (rdata_d),
        .alu_result_i (alu_result_m),
        .write_reg_i  (write_reg_m),
        .reg_write_o  (reg_write_w),
        .mem2reg_o    (mem2reg_w),
        .read_data_o  (read_data_w),
        .alu_result_o (alu_result_w),
        .write_reg_o  (write_reg_w)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage; a memory model answers requests
// and an instruction-level model predicts stall length, write-back and errors.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_m, mem2reg_m, mem_write_m;
    logic [31:0] alu_result_m, write_data_m;
    logic [4:0]  write_reg_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_m;
    logic        reg_write_w, mem2reg_w;
    logic [31:0] read_data_w, alu_result_w;
    logic [4:0]  write_reg_w;
    logic        mem_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .data_width     (32),
        .op_width       (5),
        .timeout_cycles (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reg_write_m  (reg_write_m),
        .mem2reg_m    (mem2reg_m),
        .mem_write_m  (mem_write_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .write_reg_m  (write_reg_m),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall_m      (stall_m),
        .reg_write_w  (reg_write_w),
        .mem2reg_w    (mem2reg_w),
        .read_data_w  (read_data_w),
        .alu_result_w (alu_result_w),
        .write_reg_w  (write_reg_w),
        .mem_err      (mem_err)
    );

    typedef struct packed {
        logic        done;
        logic [7:0]  stalls;
        logic [7:0]  reqs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        err;
        logic        mid_err;
        logic        mid_wb;
    } res_t;

    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    // Instruction-level expectation: ack on ACCESS cycle k (1..T) completes
    // after k stalled cycles; anything else aborts after T stalled cycles.
    function automatic res_t model(input logic rw, m2r, mw, input logic [31:0] addr,
                                   wdata, input logic [4:0] wreg, input int ack_at);
        res_t r = '0;
        r.done = 1'b1;
        if (!(m2r || mw)) begin
            r.rw = rw; r.m2r = m2r; r.alu = addr; r.wreg = wreg;
        end else if (addr % 4 != 0) begin
            r.err = 1'b1;
        end else begin
            r.we = mw; r.addr = addr; r.wdata = wdata;
            if (ack_at >= 1 && ack_at <= T) begin
                r.stalls = 8'(ack_at); r.reqs = 8'(ack_at);
                r.rw = rw; r.m2r = m2r; r.alu = addr; r.wreg = wreg;
                r.rdata = m2r ? memrd(addr) : 32'h0;
            end else begin
                r.stalls = 8'(T); r.reqs = 8'(T); r.err = 1'b1;
            end
        end
        return r;
    endfunction

    // Present one instruction (entered just after a rising edge) and run it
    // until the stage stops stalling; the memory acks on ACCESS cycle ack_at.
    task automatic exec(input logic rw, m2r, mw, input logic [31:0] addr, wdata,
                        input logic [4:0] wreg, input int ack_at, output res_t o);
        logic st;
        o = '0;
        reg_write_m = rw; mem2reg_m = m2r; mem_write_m = mw;
        alu_result_m = addr; write_data_m = wdata; write_reg_m = wreg;
        for (int i = 0; i < T + 3; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                o.reqs++;
                o.we = dmem_we; o.addr = dmem_addr; o.wdata = dmem_wdata;
                dmem_ack   = (int'(o.reqs) == ack_at);
                dmem_rdata = dmem_ack ? memrd(dmem_addr) : $urandom;
                if (dmem_ack && dmem_we) mem_model[dmem_addr] = dmem_wdata;
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            #1;
            st = stall_m;
            if (st) o.stalls++;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (!st) begin
                o.done = 1'b1;
                o.rw = reg_write_w; o.m2r = mem2reg_w; o.rdata = read_data_w;
                o.alu = alu_result_w; o.wreg = write_reg_w; o.err = mem_err;
                break;
            end
            if (mem_err) o.mid_err = 1'b1;
            if (reg_write_w || mem2reg_w || read_data_w != 0 || alu_result_w != 0 ||
                write_reg_w != 0) o.mid_wb = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        reg_write_m = 0; mem2reg_m = 0; mem_write_m = 0;
        alu_result_m = 0; write_data_m = 0; write_reg_m = 0;
        dmem_ack = 0; dmem_rdata = 0;
        #12;
        total_cnt++;
        if ({dmem_req, stall_m, reg_write_w, mem2reg_w, read_data_w, alu_result_w,
             write_reg_w, mem_err} !== '0)
            $display("FAIL reset_state: got req=%b stall=%b rw=%b m2r=%b rd=%h alu=%h wr=%0d err=%b want all 0",
                     dmem_req, stall_m, reg_write_w, mem2reg_w, read_data_w, alu_result_w,
                     write_reg_w, mem_err);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_op;
        res_t o, e;
        e = model(1, 0, 0, 32'h40, 32'h0, 5'd5, 0);
        exec(1, 0, 0, 32'h40, 32'h0, 5'd5, 0, o);
        total_cnt++;
        if (o !== e) $display("FAIL alu_op: got %p want %p", o, e); else pass_cnt++;
    endtask

    task automatic test_load_wait;
        res_t o, e;
        mem_model[32'h100] = 32'hDEAD_BEEF;
        e = model(1, 1, 0, 32'h100, 32'h0, 5'd7, 3);
        exec(1, 1, 0, 32'h100, 32'h0, 5'd7, 3, o);
        total_cnt++;
        if (o !== e) $display("FAIL load_wait: got %p want %p", o, e); else pass_cnt++;
        total_cnt++;
        if (o.rdata !== 32'hDEAD_BEEF || o.stalls !== 8'd3)
            $display("FAIL load_data: got rd=%h stalls=%0d want DEADBEEF/3", o.rdata, o.stalls);
        else pass_cnt++;
    endtask

    task automatic test_store;
        res_t o, e;
        e = model(0, 0, 1, 32'h104, 32'h1234_5678, 5'd0, 1);
        exec(0, 0, 1, 32'h104, 32'h1234_5678, 5'd0, 1, o);
        total_cnt++;
        if (o !== e) $display("FAIL store: got %p want %p", o, e); else pass_cnt++;
        total_cnt++;
        if (o.we !== 1'b1 || o.wdata !== 32'h1234_5678 || o.reqs !== 8'd1)
            $display("FAIL store_port: got we=%b wdata=%h reqs=%0d want 1/12345678/1",
                     o.we, o.wdata, o.reqs);
        else pass_cnt++;
    endtask

    task automatic test_misaligned;
        res_t o, e;
        e = model(1, 1, 0, 32'h102, 32'h0, 5'd3, 1);
        exec(1, 1, 0, 32'h102, 32'h0, 5'd3, 1, o);
        total_cnt++;
        if (o !== e) $display("FAIL misaligned: got %p want %p", o, e); else pass_cnt++;
    endtask

    task automatic test_timeout;
        res_t o, e;
        e = model(1, 1, 0, 32'h200, 32'h0, 5'd9, 0);
        exec(1, 1, 0, 32'h200, 32'h0, 5'd9, 0, o);
        total_cnt++;
        if (o !== e) $display("FAIL timeout_abort: got %p want %p", o, e); else pass_cnt++;
        e = model(1, 1, 0, 32'h204, 32'h0, 5'd10, T);
        exec(1, 1, 0, 32'h204, 32'h0, 5'd10, T, o);
        total_cnt++;
        if (o !== e) $display("FAIL ack_last_cycle: got %p want %p", o, e); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        res_t o, e;
        e = model(0, 0, 1, 32'h300, 32'hCAFE_0001, 5'd0, 2);
        exec(0, 0, 1, 32'h300, 32'hCAFE_0001, 5'd0, 2, o);
        total_cnt++;
        if (o !== e) $display("FAIL b2b_store: got %p want %p", o, e); else pass_cnt++;
        e = model(1, 1, 0, 32'h300, 32'h0, 5'd12, 1);
        exec(1, 1, 0, 32'h300, 32'h0, 5'd12, 1, o);
        total_cnt++;
        if (o !== e || o.rdata !== 32'hCAFE_0001)
            $display("FAIL b2b_load: got %p want %p", o, e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access;
        res_t o, e;
        reg_write_m = 1; mem2reg_m = 1; mem_write_m = 0;
        alu_result_m = 32'h400; write_data_m = 0; write_reg_m = 5'd4;
        @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++;
        if (dmem_req !== 1'b1) $display("FAIL mid_access_req: got %b want 1", dmem_req);
        else pass_cnt++;
        #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({dmem_req, stall_m, reg_write_w, mem2reg_w, read_data_w, alu_result_w,
             write_reg_w, mem_err} !== '0)
            $display("FAIL reset_mid_access: got req=%b stall=%b rw=%b m2r=%b err=%b want all 0",
                     dmem_req, stall_m, reg_write_w, mem2reg_w, mem_err);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        reg_write_m = 0; mem2reg_m = 0;
        @(posedge clk);
        #1;
        e = model(1, 1, 0, 32'h104, 32'h0, 5'd6, 2);
        exec(1, 1, 0, 32'h104, 32'h0, 5'd6, 2, o);
        total_cnt++;
        if (o !== e) $display("FAIL load_after_reset: got %p want %p", o, e); else pass_cnt++;
    endtask

    task automatic test_random;
        res_t o, e;
        logic rw, m2r, mw;
        logic [31:0] addr, wd;
        logic [4:0] wr;
        int ack_at, kind;
        for (int n = 0; n < 40; n++) begin
            kind   = int'($urandom_range(0, 2));
            rw     = (kind != 2) ? 1'b1 : 1'($urandom_range(0, 1));
            m2r    = (kind == 1);
            mw     = (kind == 2);
            addr   = 32'h500 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
            if (kind == 0) addr = $urandom;
            wd     = $urandom;
            wr     = 5'($urandom);
            ack_at = int'($urandom_range(0, T + 1));
            e = model(rw, m2r, mw, addr, wd, wr, ack_at);
            exec(rw, m2r, mw, addr, wd, wr, ack_at, o);
            total_cnt++;
            if (o !== e) $display("FAIL random_%0d: got %p want %p", n, o, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_alu_op;
        test_load_wait;
        test_store;
        test_misaligned;
        test_timeout;
        test_back_to_back;
        test_reset_mid_access;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage pipelined MIPS core. Consumes the EX/MEM pipeline-register outputs, performs loads and stores on a handshaked data-memory port, stalls the upstream pipeline while an access is outstanding, and drives the MEM/WB pipeline register feeding write-back. It flags misaligned and timed-out accesses and turns them into write-back bubbles.

## Interface
**Parameters**
- `data_width`, 32, data/address width
- `op_width`, 5, register-file address width
- `timeout_cycles`, 16, maximum ACCESS cycles without `dmem_ack` before abort; must be ≥1

**Ports**
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `reg_write_m`, `mem2reg_m`, `mem_write_m`  in  1 each  EX/MEM control
- `alu_result_m`  in  data_width  memory address / ALU result
- `write_data_m`  in  data_width  store data
- `write_reg_m`  in  op_width  destination register
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  data_width  byte address
- `dmem_wdata`  out  data_width  store data
- `dmem_rdata`  in  data_width  load data, valid with `dmem_ack`
- `dmem_ack`  in  1  access complete
- `stall_m`  out  1  hold EX/MEM and all earlier stages
- `reg_write_w`, `mem2reg_w`  out  1 each  MEM/WB control
- `read_data_w`, `alu_result_w`  out  data_width  MEM/WB data
- `write_reg_w`  out  op_width  MEM/WB destination
- `mem_err`  out  1  one-cycle error pulse

## Operation
- `mem_op = mem2reg_m | mem_write_m`. `aligned = (alu_result_m[1:0] == 0)`.
- FSM states: IDLE, ACCESS. Reset → IDLE.
- IDLE, `!mem_op`: `stall_m` = 0. MEM/WB loads the inputs at the edge. `read_data_w` loads 0.
- IDLE, `mem_op && aligned`: `stall_m` = 1. MEM/WB loads a bubble (all fields 0). Next state is ACCESS and the wait counter clears.
- IDLE, `mem_op && !aligned`: no request and `stall_m` = 0. MEM/WB loads a bubble. `mem_err` = 1 for the next cycle. State stays IDLE.
- ACCESS drives the memory port: `dmem_req` = 1, `dmem_we` = `mem_write_m`, `dmem_addr` = `alu_result_m`, `dmem_wdata` = `write_data_m`. Inputs are stable because upstream is stalled.
- ACCESS with `dmem_ack`:
  - `stall_m` = 0.
  - MEM/WB loads the instruction. `read_data_w` = `dmem_rdata` for loads, 0 for stores.
  - Next state is IDLE.
- ACCESS, no ack, `wait_cnt < timeout_cycles-1`: `stall_m` = 1, the counter increments, and MEM/WB loads a bubble.
- ACCESS, no ack, `wait_cnt == timeout_cycles-1`: abort.
  - `stall_m` = 0, so the faulting instruction is dropped.
  - MEM/WB loads a bubble and `mem_err` pulses the next cycle.
  - Next state is IDLE.
- `dmem_ack` in IDLE is ignored. Ack in the timeout cycle wins over abort.
- Outside ACCESS: `dmem_req` = 0, `dmem_we` = 0, `dmem_addr`/`dmem_wdata` = 0.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE and the counter to 0.
  - All MEM/WB outputs and `mem_err` go to 0.
  - `dmem_req` and `stall_m` drop in the same cycle, including mid-ACCESS. The in-flight access is abandoned.
- Non-memory instruction: 1-cycle latency, EX/MEM to MEM/WB at the next edge.
- Memory instruction:
  - Minimum 2 edges: IDLE detect, then ACCESS with ack.
  - Each extra wait cycle adds 1 edge.
  - Worst case is `timeout_cycles` + 1 edges, then abort.
- `stall_m` is combinational from state, `mem_op`, `aligned`, `dmem_ack` and the counter. It has no path from MEM/WB outputs.
- Back-to-back memory ops: the second enters IDLE the cycle after the first's ack. Throughput is one memory op per ≥2 cycles.
- Wait counter width is `$clog2(timeout_cycles)`, minimum 1 bit. It never wraps, because abort fires first.
- `mem_err` is registered: high exactly one cycle after the detecting edge, otherwise 0.

## Structure
- Shared package `mips_pkg`: `mem_state_t` enum {IDLE, ACCESS}, default `data_width`/`op_width` constants, and the `timeout_cycles` default.
- Sub-module `mem_wb_pipe_reg`: MEM/WB register with async active-high reset and a bubble input. The FSM, counter, port drive and `stall_m` logic stay in `mem_access_stage`.

## Test plan
- ALU op (`reg_write_m`=1, `alu_result_m`=0x0000_0040, `write_reg_m`=5, no mem) → next edge: `reg_write_w`=1, `alu_result_w`=0x40, `write_reg_w`=5, `stall_m` never 1.
- Load at 0x100, ack on 3rd ACCESS cycle with `dmem_rdata`=0xDEAD_BEEF → `stall_m` high 3 cycles, then `read_data_w`=0xDEADBEEF, `mem2reg_w`=1.
- Store at 0x104, `write_data_m`=0x1234_5678, ack on first ACCESS cycle → `dmem_we`=1, `dmem_wdata`=0x12345678 for 1 cycle; `reg_write_w`=0, `read_data_w`=0.
- Load at 0x102 (misaligned) → `dmem_req` stays 0, `mem_err` pulses 1 cycle, MEM/WB bubble, no stall.
- `timeout_cycles`=4, no ack → `stall_m` high 4 cycles, `mem_err` pulse, bubble. Repeat with ack in the 4th cycle → normal completion, no error.
- Assert `reset` mid-ACCESS → `dmem_req`, `stall_m` and all MEM/WB outputs 0 immediately. After release, state is IDLE and a new load completes normally.
